// File: rtl/rvfi_pc_chain_check.sv
// PC-chain checker: follows retirement K and its successor K+1 across NRET
// RVFI channels and reports continuity, duplicate, order, alignment, timeout.
// Ports: clk, reset (sync, active-high), enable, check_order, rvfi_valid,
//   rvfi_order, rvfi_pre_pc, rvfi_post_pc, rvfi_post_trap -> check_busy,
//   check_done, check_fail, fail_code, first_trap.
// Optional: define RISCV_FORMAL_PC_CHAIN_ASSERT_EN for assert/cover emission.
module rvfi_pc_chain_check #(
  parameter int NRET    = 1,
  parameter int XLEN    = 32,
  parameter int ORDER_W = 64,
  parameter int MAX_GAP = 16,
  parameter int IALIGN  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [ORDER_W-1:0]      check_order,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*ORDER_W-1:0] rvfi_order,
  input  logic [NRET*XLEN-1:0]    rvfi_pre_pc,
  input  logic [NRET*XLEN-1:0]    rvfi_post_pc,
  input  logic [NRET-1:0]         rvfi_post_trap,
  output logic                    check_busy,
  output logic                    check_done,
  output logic                    check_fail,
  output logic [2:0]              fail_code,
  output logic                    first_trap
);

  localparam int GW = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
  localparam logic [GW-1:0] GAP_LIM = GW'(MAX_GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRST, S_NEXT, S_PASS, S_FAIL
  } state_t;

  state_t             state;
  logic [ORDER_W-1:0] k;
  logic [ORDER_W-1:0] k1;
  logic [XLEN-1:0]    pc_q;
  logic [GW-1:0]      gap;
  logic [GW-1:0]      gap_inc;
  logic               gap_hit;

  logic [NRET-1:0] hit_k;
  logic [NRET-1:0] hit_k1;
  logic            k_any, k_multi;
  logic            k1_any, k1_multi;
  int              idx_k, idx_k1;
  logic [XLEN-1:0] pc_k, pc_k1, ref_pc;
  logic            trap_k, mis;
  logic            fin;
  logic [2:0]      code;

  assign k1 = k + ORDER_W'(1);

  // Saturating increment; the counter never wraps back to zero.
  assign gap_inc = (gap == '1) ? gap : gap + GW'(1);
  assign gap_hit = (MAX_GAP > 0) && (gap_inc == GAP_LIM);

  always_comb begin
    hit_k    = '0;
    hit_k1   = '0;
    k_any    = 1'b0;
    k_multi  = 1'b0;
    k1_any   = 1'b0;
    k1_multi = 1'b0;
    idx_k    = 0;
    idx_k1   = 0;
    for (int i = 0; i < NRET; i++) begin
      hit_k[i]  = enable && rvfi_valid[i] &&
                  (rvfi_order[i*ORDER_W +: ORDER_W] == k);
      hit_k1[i] = enable && rvfi_valid[i] &&
                  (rvfi_order[i*ORDER_W +: ORDER_W] == k1);
      if (hit_k[i]) begin
        if (k_any) k_multi = 1'b1;
        else       idx_k = i;
        k_any = 1'b1;
      end
      if (hit_k1[i]) begin
        if (k1_any) k1_multi = 1'b1;
        else        idx_k1 = i;
        k1_any = 1'b1;
      end
    end
  end

  assign pc_k   = rvfi_post_pc[idx_k*XLEN +: XLEN];
  assign pc_k1  = rvfi_pre_pc[idx_k1*XLEN +: XLEN];
  assign trap_k = rvfi_post_trap[idx_k];
  assign mis    = (IALIGN == 16) ? pc_k1[0] : |pc_k1[1:0];
  // Same-cycle pairs chain directly off K's post_pc.
  assign ref_pc = (state == S_FIRST) ? pc_k : pc_q;

  // Decision for this cycle; priority 3 > 4 > 1 > 5 > 2.
  always_comb begin
    fin  = 1'b0;
    code = 3'd0;
    unique case (state)
      S_FIRST: begin
        if (k_multi || k1_multi) begin
          fin  = 1'b1;
          code = 3'd3;
        end else if (k1_any && (!k_any || idx_k1 < idx_k)) begin
          fin  = 1'b1;
          code = 3'd4;
        end else if (k_any && k1_any) begin
          fin = 1'b1;
          if (pc_k1 != ref_pc) code = 3'd1;
          else if (mis)        code = 3'd5;
        end
      end
      S_NEXT: begin
        if (k_any || k1_multi) begin
          fin  = 1'b1;
          code = 3'd3;
        end else if (k1_any) begin
          fin = 1'b1;
          if (pc_k1 != ref_pc) code = 3'd1;
          else if (mis)        code = 3'd5;
        end else if (gap_hit) begin
          fin  = 1'b1;
          code = 3'd2;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= '0;
      pc_q       <= '0;
      gap        <= '0;
      check_busy <= 1'b0;
      check_done <= 1'b0;
      check_fail <= 1'b0;
      fail_code  <= 3'd0;
      first_trap <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          k          <= check_order;
          state      <= S_FIRST;
          check_busy <= 1'b1;
        end
        S_FIRST, S_NEXT: begin
          if (state == S_FIRST && k_any && !k_multi)
            first_trap <= trap_k;
          if (fin) begin
            state      <= (code != 3'd0) ? S_FAIL : S_PASS;
            check_busy <= 1'b0;
            check_done <= 1'b1;
            check_fail <= (code != 3'd0);
            fail_code  <= code;
          end else if (state == S_FIRST) begin
            if (k_any) begin
              pc_q  <= pc_k;
              gap   <= '0;
              state <= S_NEXT;
            end
          end else begin
            gap <= gap_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RISCV_FORMAL_PC_CHAIN_ASSERT_EN
  logic fail_q;

  always_ff @(posedge clk) begin
    fail_q <= check_fail;
    if (!reset) begin
      assert (!check_fail);
      if (check_fail && !fail_q)
        cover (check_done && !check_fail);
    end
  end
`endif

endmodule

// File: tb/tb_rvfi_pc_chain_check.sv
// Directed bench for rvfi_pc_chain_check: two instances (IALIGN 32 and 16)
// share NRET=2, MAX_GAP=4 stimulus; status is {busy,done,fail,code,trap}.
module tb_rvfi_pc_chain_check;
  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [63:0]  check_order;
  logic [1:0]   valid;
  logic [127:0] order;
  logic [63:0]  pre_pc;
  logic [63:0]  post_pc;
  logic [1:0]   trap;

  logic       a_busy, a_done, a_fail, a_trap;
  logic [2:0] a_code;
  logic       b_busy, b_done, b_fail, b_trap;
  logic [2:0] b_code;
  logic [6:0] st_a, st_b;

  int cmp = 0;
  int bad = 0;

  assign st_a = {a_busy, a_done, a_fail, a_code, a_trap};
  assign st_b = {b_busy, b_done, b_fail, b_code, b_trap};

  always #5 clk = ~clk;

  rvfi_pc_chain_check #(
    .NRET(2), .XLEN(32), .ORDER_W(64), .MAX_GAP(4), .IALIGN(32)
  ) u_a (
    .clk(clk), .reset(reset), .enable(enable),
    .check_order(check_order), .rvfi_valid(valid),
    .rvfi_order(order), .rvfi_pre_pc(pre_pc),
    .rvfi_post_pc(post_pc), .rvfi_post_trap(trap),
    .check_busy(a_busy), .check_done(a_done),
    .check_fail(a_fail), .fail_code(a_code),
    .first_trap(a_trap)
  );

  rvfi_pc_chain_check #(
    .NRET(2), .XLEN(32), .ORDER_W(64), .MAX_GAP(4), .IALIGN(16)
  ) u_b (
    .clk(clk), .reset(reset), .enable(enable),
    .check_order(check_order), .rvfi_valid(valid),
    .rvfi_order(order), .rvfi_pre_pc(pre_pc),
    .rvfi_post_pc(post_pc), .rvfi_post_trap(trap),
    .check_busy(b_busy), .check_done(b_done),
    .check_fail(b_fail), .fail_code(b_code),
    .first_trap(b_trap)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    valid = '0;
    trap  = '0;
  endtask

  task automatic put(input int ch, input logic [63:0] o,
                     input logic [31:0] pre, input logic [31:0] post,
                     input logic tr);
    valid[ch]          = 1'b1;
    order[ch*64 +: 64] = o;
    pre_pc[ch*32 +: 32]  = pre;
    post_pc[ch*32 +: 32] = post;
    trap[ch]           = tr;
  endtask

  task automatic start(input logic [63:0] kk);
    reset       = 1'b1;
    check_order = kk;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    cmp++;
    if (st_a !== 7'b0000000) begin
      bad++;
      $display("FAIL reset_state: got %b want %b", st_a, 7'b0000000);
    end
    reset       = 1'b0;
    check_order = 64'd5;
    tick();
    cmp++;
    if (st_a !== 7'b1000000) begin
      bad++;
      $display("FAIL armed: got %b want %b", st_a, 7'b1000000);
    end
  endtask

  task automatic test_pass_gap();
    start(64'd5);
    put(0, 64'd5, 32'h0fc, 32'h100, 1'b0);
    tick();
    tick();
    tick();
    tick();
    cmp++;
    if (st_a !== 7'b1000000) begin
      bad++;
      $display("FAIL gap3_busy: got %b want %b", st_a, 7'b1000000);
    end
    put(0, 64'd6, 32'h100, 32'h104, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0100000) begin
      bad++;
      $display("FAIL pass_gap: got %b want %b", st_a, 7'b0100000);
    end
  endtask

  task automatic test_same_cycle();
    start(64'd7);
    put(0, 64'd7, 32'h2000, 32'h2004, 1'b0);
    put(1, 64'd8, 32'h2008, 32'h200c, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0110010) begin
      bad++;
      $display("FAIL same_mismatch: got %b want %b", st_a, 7'b0110010);
    end
    start(64'd7);
    put(0, 64'd7, 32'h2000, 32'h2004, 1'b0);
    put(1, 64'd8, 32'h2004, 32'h2008, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0100000) begin
      bad++;
      $display("FAIL same_pass: got %b want %b", st_a, 7'b0100000);
    end
  endtask

  task automatic test_timeout();
    start(64'd3);
    put(0, 64'd3, 32'h40, 32'h44, 1'b0);
    tick();
    tick();
    tick();
    tick();
    cmp++;
    if (st_a !== 7'b1000000) begin
      bad++;
      $display("FAIL pre_timeout: got %b want %b", st_a, 7'b1000000);
    end
    tick();
    cmp++;
    if (st_a !== 7'b0110100) begin
      bad++;
      $display("FAIL timeout: got %b want %b", st_a, 7'b0110100);
    end
  endtask

  task automatic test_duplicate();
    start(64'd4);
    put(0, 64'd4, 32'h10, 32'h14, 1'b0);
    put(1, 64'd4, 32'h10, 32'h14, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0110110) begin
      bad++;
      $display("FAIL dup_same: got %b want %b", st_a, 7'b0110110);
    end
    start(64'd4);
    put(0, 64'd4, 32'h10, 32'h14, 1'b0);
    tick();
    put(1, 64'd4, 32'h14, 32'h18, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0110110) begin
      bad++;
      $display("FAIL dup_next: got %b want %b", st_a, 7'b0110110);
    end
  endtask

  task automatic test_order();
    start(64'd4);
    put(0, 64'd5, 32'h14, 32'h18, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0111000) begin
      bad++;
      $display("FAIL early_succ: got %b want %b", st_a, 7'b0111000);
    end
    start(64'd4);
    put(0, 64'd5, 32'h14, 32'h18, 1'b0);
    put(1, 64'd4, 32'h10, 32'h14, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0111000) begin
      bad++;
      $display("FAIL low_succ: got %b want %b", st_a, 7'b0111000);
    end
  endtask

  task automatic test_align();
    start(64'd1);
    put(0, 64'd1, 32'h0fe, 32'h102, 1'b0);
    tick();
    put(0, 64'd2, 32'h102, 32'h104, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0111010) begin
      bad++;
      $display("FAIL align32: got %b want %b", st_a, 7'b0111010);
    end
    cmp++;
    if (st_b !== 7'b0100000) begin
      bad++;
      $display("FAIL align16: got %b want %b", st_b, 7'b0100000);
    end
  endtask

  task automatic test_reset_mid();
    start(64'd20);
    put(0, 64'd20, 32'h80, 32'h84, 1'b1);
    tick();
    reset       = 1'b1;
    check_order = 64'd9;
    tick();
    cmp++;
    if ({st_a, st_b} !== 14'd0) begin
      bad++;
      $display("FAIL mid_reset: got %b/%b want 0", st_a, st_b);
    end
    reset = 1'b0;
    tick();
    put(1, 64'd9, 32'h2fc, 32'h300, 1'b0);
    tick();
    put(0, 64'd10, 32'h300, 32'h304, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0100000) begin
      bad++;
      $display("FAIL after_reset: got %b want %b", st_a, 7'b0100000);
    end
  endtask

  task automatic test_enable_trap();
    start(64'd2);
    enable = 1'b0;
    put(0, 64'd2, 32'h20, 32'h24, 1'b0);
    tick();
    enable = 1'b1;
    cmp++;
    if (st_a !== 7'b1000000) begin
      bad++;
      $display("FAIL masked: got %b want %b", st_a, 7'b1000000);
    end
    put(0, 64'd3, 32'h24, 32'h28, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0111000) begin
      bad++;
      $display("FAIL masked_k: got %b want %b", st_a, 7'b0111000);
    end
    start(64'd2);
    put(1, 64'd2, 32'h20, 32'h80, 1'b1);
    tick();
    put(0, 64'd3, 32'h80, 32'h84, 1'b0);
    tick();
    put(0, 64'd3, 32'h99, 32'h84, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0100001) begin
      bad++;
      $display("FAIL trap_rec: got %b want %b", st_a, 7'b0100001);
    end
  endtask

  task automatic test_wrap();
    start('1);
    put(0, '1, 32'h500, 32'h504, 1'b0);
    tick();
    put(1, 64'd0, 32'h504, 32'h508, 1'b0);
    tick();
    cmp++;
    if (st_a !== 7'b0100000) begin
      bad++;
      $display("FAIL wrap: got %b want %b", st_a, 7'b0100000);
    end
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b1;
    check_order = '0;
    valid       = '0;
    order       = '0;
    pre_pc      = '0;
    post_pc     = '0;
    trap        = '0;
    #2;
    test_reset();
    test_pass_gap();
    test_same_cycle();
    test_timeout();
    test_duplicate();
    test_order();
    test_align();
    test_reset_mid();
    test_enable_trap();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule

// File: doc/rvfi_pc_chain_check.md
Name: rvfi_pc_chain_check

Overview:
- Sequential successor to the per-channel instruction checker. Tracks one chosen retirement (order K) and its successor (order K+1) across any of NRET RVFI channels.
- Verifies PC continuity: pre_pc(K+1) == post_pc(K).
- Adds duplicate-order, out-of-order and timeout detection, plus IALIGN alignment checking.
- Sits beside the instruction checks in the formal/simulation testbench and consumes the same flattened RVFI buses.

Parameters:
- NRET, 1, number of retirement channels.
- XLEN, 32, PC width (32 or 64).
- ORDER_W, 64, width of rvfi_order per channel.
- MAX_GAP, 16, max cycles allowed between retiring K and K+1; 0 disables the timeout.
- IALIGN, 32, instruction alignment in bits (16 or 32); pre_pc(K+1) must be aligned to it.

Ports:
- clk, input, 1, sole clock.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, qualifies all rvfi_valid bits.
- check_order, input, ORDER_W, order K under test; sampled on the first cycle after reset, held internally.
- rvfi_valid, input, NRET, per-channel retire strobe.
- rvfi_order, input, NRET*ORDER_W, per-channel instruction order.
- rvfi_pre_pc, input, NRET*XLEN, PC of the retiring instruction.
- rvfi_post_pc, input, NRET*XLEN, next PC after the retiring instruction.
- rvfi_post_trap, input, NRET, trap flag (informational; recorded only).
- check_busy, output, 1, checker armed and not yet concluded.
- check_done, output, 1, check concluded (sticky until reset).
- check_fail, output, 1, concluded with an error (sticky).
- fail_code, output, 3, 0 none, 1 PC mismatch, 2 timeout, 3 duplicate order, 4 successor before K, 5 misaligned successor PC.
- first_trap, output, 1, post_trap of order K as recorded.

Behaviour:
- Reset (synchronous, highest priority, valid mid-check):
  - state=IDLE; check_busy=0, check_done=0, check_fail=0, fail_code=0, first_trap=0.
  - Gap counter=0; stored PC=0.
- Channel hit rules:
  - Hit(K) = enable & rvfi_valid[i] & order_i==K.
  - Hit(K+1) = same with order_i==K+1. K+1 is computed modulo 2^ORDER_W.
- States:
  - IDLE: next cycle latch check_order into K, go WAIT_FIRST, check_busy=1.
  - WAIT_FIRST:
    - Hit(K+1) with no Hit(K) in the same cycle: FAIL code 4.
    - Hit(K) on more than one channel: FAIL code 3.
    - Hit(K) on one channel with Hit(K+1) on a higher-indexed channel in the same cycle: compare combinationally and go straight to PASS or FAIL. K+1 on a lower index than K is code 4.
    - Otherwise Hit(K): store post_pc and post_trap, clear gap counter, go WAIT_NEXT.
  - WAIT_NEXT:
    - Any Hit(K): FAIL code 3.
    - Hit(K+1) on more than one channel: FAIL code 3.
    - Single Hit(K+1): pre_pc != stored PC gives code 1; otherwise pre_pc misaligned to IALIGN/8 bytes gives code 5; otherwise PASS.
    - No hit: increment gap counter. If MAX_GAP>0 and the counter reaches MAX_GAP, FAIL code 2.
  - PASS / FAIL: terminal; check_done=1, check_busy=0, check_fail=(FAIL). Later retirements are ignored.
- Latency: state, flags and fail_code update at the clk edge following the deciding retirement (1-cycle registered outputs).
- Priority when several errors coincide in one cycle: code 3 > 4 > 1 > 5 > 2.
- Counter width is $clog2(MAX_GAP+1), min 1. It saturates and never wraps.
- XLEN=32: PCs are compared on all 32 bits; no sign extension.

Optional Feature:
- Macro RISCV_FORMAL_PC_CHAIN_ASSERT_EN.
- Defined: additionally emits immediate assert(!check_fail) in a clocked block, gated by !reset. In the cycle check_fail rises, also emits cover(check_done && !check_fail).
- Undefined: no assert/cover statements. Results are reported only through the output ports, so the block is usable in pure simulation.

Test Plan:
- NRET=1, K=5: order 5 retires with post_pc=0x100, then 3 idle cycles, then order 6 with pre_pc=0x100 -> check_done=1, check_fail=0, fail_code=0 one cycle after order 6.
- NRET=2, K=7, same cycle: ch0 order 7 post_pc=0x2004, ch1 order 8 pre_pc=0x2008 -> next cycle check_fail=1, fail_code=1.
- MAX_GAP=4: order K retires, then no retirement for 4 cycles -> after the 4th idle cycle check_fail=1, fail_code=2.
- NRET=2: ch0 and ch1 both report order K in one cycle -> fail_code=3. Separately, order K+1 arrives before K -> fail_code=4.
- IALIGN=32: K post_pc=0x102, K+1 pre_pc=0x102 -> fail_code=5. Repeat with IALIGN=16 -> pass.
- Assert reset in WAIT_NEXT, release with check_order=9, run a correct 9->10 sequence -> all outputs 0 during reset, then pass. Also cover enable=0 masking a matching retirement: no state change.
